// File: rtl/gol_board_if.sv
// Edit stream from the user-input block and the board's LED/status outputs.
// The master drives edits and run mode. The slave is the board engine.
interface gol_board_if;
    logic                 start_game;
    logic [7:0]           row_select;
    logic [7:0]           col_select;
    logic                 set_initial;
    logic                 cell_state;
    logic [15:0][15:0]    RedPixels;
    logic [15:0]          gen_count;
    logic                 gen_tick;
    logic                 extinct;

    modport master (
        output start_game, row_select, col_select, set_initial, cell_state,
        input  RedPixels, gen_count, gen_tick, extinct
    );

    modport slave (
        input  start_game, row_select, col_select, set_initial, cell_state,
        output RedPixels, gen_count, gen_tick, extinct
    );
endinterface

// File: rtl/gol_board.sv
// 16x16 Game-of-Life board: single-cell edits in EDIT, one generation per GEN_INTERVAL clocks in RUN.
// Define GOL_WRAP_EN for a toroidal board; by default cells beyond the edge are dead.
module gol_board #(
    parameter int unsigned GEN_INTERVAL = 1000000
) (
    input logic       clk,
    input logic       reset,
    gol_board_if.slave bus
);
    typedef enum logic {StEdit, StRun} state_e;

    state_e            state_q, state_d;
    logic [31:0]       cnt_q, cnt_d;
    logic [15:0][15:0] board_q, board_d;
    logic [15:0][15:0] board_next;
    logic [15:0]       gen_count_q, gen_count_d;
    logic              gen_tick_q, gen_tick_d;
    logic              gen_due;

    // Board framed by a one-cell border so every neighbour index is in range.
    logic [17:0][17:0] pad;

`ifdef GOL_WRAP_EN
    assign pad[0]  = {board_q[15][0], board_q[15], board_q[15][15]};
    assign pad[17] = {board_q[0][0], board_q[0], board_q[0][15]};
`else
    assign pad[0]  = '0;
    assign pad[17] = '0;
`endif

    for (genvar r = 0; r < 16; r++) begin : g_pad_row
`ifdef GOL_WRAP_EN
        assign pad[r+1] = {board_q[r][0], board_q[r], board_q[r][15]};
`else
        assign pad[r+1] = {1'b0, board_q[r], 1'b0};
`endif
    end

    for (genvar r = 0; r < 16; r++) begin : g_row
        for (genvar c = 0; c < 16; c++) begin : g_col
            logic [3:0] nsum;
            // pad[r+1][c+1] is this cell; sum the ring around it.
            assign nsum = 4'(pad[r][c])     + 4'(pad[r][c+1])   + 4'(pad[r][c+2])
                        + 4'(pad[r+1][c])                       + 4'(pad[r+1][c+2])
                        + 4'(pad[r+2][c])   + 4'(pad[r+2][c+1]) + 4'(pad[r+2][c+2]);
            assign board_next[r][c] = (nsum == 4'd3) || (board_q[r][c] && nsum == 4'd2);
        end
    end

    assign gen_due = (cnt_q == GEN_INTERVAL - 1);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        board_d     = board_q;
        gen_count_d = gen_count_q;
        gen_tick_d  = 1'b0;
        unique case (state_q)
            StEdit: begin
                cnt_d = '0;
                if (bus.set_initial && bus.row_select < 8'd16 && bus.col_select < 8'd16) begin
                    board_d[bus.row_select[3:0]][bus.col_select[3:0]] = bus.cell_state;
                end
                if (bus.start_game) state_d = StRun;
            end
            StRun: begin
                if (gen_due) begin
                    cnt_d      = '0;
                    board_d    = board_next;
                    gen_tick_d = 1'b1;
                    if (gen_count_q != 16'hFFFF) gen_count_d = gen_count_q + 16'd1;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
                // A generation due on this edge still commits before leaving RUN.
                if (!bus.start_game) state_d = StEdit;
            end
            default: state_d = StEdit;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StEdit;
            cnt_q       <= '0;
            board_q     <= '0;
            gen_count_q <= '0;
            gen_tick_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            board_q     <= board_d;
            gen_count_q <= gen_count_d;
            gen_tick_q  <= gen_tick_d;
        end
    end

    assign bus.RedPixels = board_q;
    assign bus.gen_count = gen_count_q;
    assign bus.gen_tick  = gen_tick_q;
    assign bus.extinct   = ~|board_q;
endmodule

// File: tb/tb_gol_board.sv
// Bench for gol_board: directed scenarios plus random edits/run toggles, all checked every
// cycle against a cell-by-cell Life model built from the game rules.
module tb_gol_board;
    localparam int unsigned GI = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    gol_board_if bus ();

    gol_board #(.GEN_INTERVAL(GI)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: board as plain integers, mode flag and clock count within a generation.
    int m_cell[16][16];
    int m_run;
    int m_cnt;
    int m_gen;
    int m_tick;

    function automatic int live_neighbours(int r, int c);
        int n = 0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                int rr = r + dr;
                int cc = c + dc;
                if (dr == 0 && dc == 0) continue;
`ifdef GOL_WRAP_EN
                rr = (rr + 16) % 16;
                cc = (cc + 16) % 16;
`else
                if (rr < 0 || rr > 15 || cc < 0 || cc > 15) continue;
`endif
                n += m_cell[rr][cc];
            end
        end
        return n;
    endfunction

    task automatic model_generation();
        int nxt[16][16];
        for (int r = 0; r < 16; r++) begin
            for (int c = 0; c < 16; c++) begin
                int n = live_neighbours(r, c);
                nxt[r][c] = (n == 3 || (m_cell[r][c] == 1 && n == 2)) ? 1 : 0;
            end
        end
        m_cell = nxt;
    endtask

    task automatic model_step();
        m_tick = 0;
        if (reset) begin
            for (int r = 0; r < 16; r++) for (int c = 0; c < 16; c++) m_cell[r][c] = 0;
            m_run = 0;
            m_cnt = 0;
            m_gen = 0;
            return;
        end
        if (m_run == 0) begin
            if (bus.set_initial && bus.row_select <= 15 && bus.col_select <= 15)
                m_cell[int'(bus.row_select)][int'(bus.col_select)] = int'(bus.cell_state);
            m_cnt = 0;
        end else if (m_cnt == int'(GI) - 1) begin
            model_generation();
            m_cnt  = 0;
            m_tick = 1;
            if (m_gen < 65535) m_gen++;
        end else begin
            m_cnt++;
        end
        m_run = bus.start_game ? 1 : 0;
    endtask

    function automatic logic [255:0] model_pix();
        logic [255:0] p = '0;
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++) p[r*16+c] = (m_cell[r][c] != 0);
        return p;
    endfunction

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        check("pixels", bus.RedPixels, model_pix());
        check("gen_count", 256'(bus.gen_count), 256'(m_gen));
        check("gen_tick", 256'(bus.gen_tick), 256'(m_tick));
        check("extinct", 256'(bus.extinct), 256'(model_pix() == '0));
    endtask

    task automatic edit(input int r, input int c, input int v);
        bus.row_select  = 8'(r);
        bus.col_select  = 8'(c);
        bus.cell_state  = v[0];
        bus.set_initial = 1'b1;
        step();
        bus.set_initial = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    logic [255:0] exp_pix;
    logic [15:0]  gen_hold;

    initial begin
        reset           = 1'b1;
        bus.start_game  = 1'b0;
        bus.row_select  = '0;
        bus.col_select  = '0;
        bus.set_initial = 1'b0;
        bus.cell_state  = 1'b0;
        step();
        do_reset();

        // Horizontal blinker through edits.
        edit(7, 6, 1);
        edit(7, 7, 1);
        edit(7, 8, 1);
        check("row7_after_edit", 256'(bus.RedPixels[7]), 256'(16'h01C0));

        bus.start_game = 1'b1;
        step();
        repeat (GI) step();
        exp_pix = '0;
        exp_pix[6*16+7] = 1'b1;
        exp_pix[7*16+7] = 1'b1;
        exp_pix[8*16+7] = 1'b1;
        check("blinker_vertical", bus.RedPixels, exp_pix);
        check("blinker_gen1", 256'(bus.gen_count), 256'(16'd1));
        repeat (GI) step();
        check("blinker_horizontal", 256'(bus.RedPixels[7]), 256'(16'h01C0));

        // Strobes in RUN and out-of-range strobes in EDIT are dropped.
        edit(2, 2, 1);
        bus.start_game = 1'b0;
        repeat (3) step();
        exp_pix = bus.RedPixels;
        edit(16, 3, 1);
        edit(3, 16, 1);
        edit(200, 200, 1);
        check("oob_edit_ignored", bus.RedPixels, exp_pix);

        // Reset in the middle of a run.
        bus.start_game = 1'b1;
        repeat (3 * GI + 2) step();
        do_reset();
        check("reset_gen_count", 256'(bus.gen_count), 256'(0));
        check("reset_extinct", 256'(bus.extinct), 256'(1));
        bus.start_game = 1'b0;
        step();

        // Corner cells across the board edge.
        edit(0, 15, 1);
        edit(0, 0, 1);
        edit(0, 1, 1);
        bus.start_game = 1'b1;
        repeat (GI + 1) step();
        exp_pix = '0;
`ifdef GOL_WRAP_EN
        exp_pix[15*16+0] = 1'b1;
        exp_pix[0*16+0]  = 1'b1;
        exp_pix[1*16+0]  = 1'b1;
`endif
        check("corner_generation", bus.RedPixels, exp_pix);

        // Drop start_game on the edge the generation is due.
        bus.start_game = 1'b0;
        step();
        do_reset();
        edit(4, 3, 1);
        edit(4, 4, 1);
        edit(4, 5, 1);
        bus.start_game = 1'b1;
        step();
        repeat (GI - 1) step();
        bus.start_game = 1'b0;
        step();
        check("late_drop_commits", 256'(bus.gen_tick), 256'(1));
        gen_hold = bus.gen_count;
        repeat (10) step();
        check("late_drop_frozen", 256'(bus.gen_count), 256'(gen_hold));

        // Random edits, run toggles and occasional resets.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 19) == 0) bus.start_game = ~bus.start_game;
            bus.row_select  = 8'($urandom_range(0, 17));
            bus.col_select  = 8'($urandom_range(0, 17));
            bus.cell_state  = ($urandom_range(0, 3) != 0);
            bus.set_initial = ($urandom_range(0, 1) == 1);
            reset           = ($urandom_range(0, 199) == 0);
            step();
        end
        reset = 1'b0;
        bus.set_initial = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/gol_board.md
# gol_board

Game-of-Life board engine: the consumer of the cursor/edit stream produced by the user-input block. It holds the 16x16 cell array. In edit mode it applies single-cell writes addressed by row/column. In run mode it advances one generation every GEN_INTERVAL clocks. It drives the red LED plane alongside the green cursor plane.

## Interface
- GEN_INTERVAL, default 1000000: clocks per generation in run mode; legal range is 2 or more.
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset, sampled on posedge clk.
- start_game  input  1  level; 1 = run mode, 0 = edit mode.
- row_select  input  8  edit target row (0 = top).
- col_select  input  8  edit target column (0 = left).
- set_initial  input  1  one-cycle write strobe for the addressed cell.
- cell_state  input  1  value written on strobe (1 = alive).
- RedPixels  output  [15:0][15:0]  current board, indexed RedPixels[row][col].
- gen_count  output  16  generations computed since leaving reset; saturates at 16'hFFFF.
- gen_tick  output  1  one-cycle pulse, high in the same cycle the new generation first appears on RedPixels.
- extinct  output  1  high while every cell is 0.

## Operation
- FSM states: EDIT, RUN.
  - EDIT -> RUN when start_game = 1.
  - RUN -> EDIT when start_game = 0.
- EDIT:
  - On a cycle with set_initial = 1 and both row_select and col_select ≤ 15, cell[row_select][col_select] <= cell_state.
  - A strobe with either coordinate > 15 is ignored.
  - The interval counter is held at 0.
- RUN:
  - set_initial is ignored.
  - The interval counter counts 0 .. GEN_INTERVAL-1 and wraps.
  - On the cycle the counter equals GEN_INTERVAL-1, every cell loads its next state:
    - alive with 2 or 3 live neighbours -> alive;
    - dead with exactly 3 live neighbours -> alive;
    - otherwise dead.
- Neighbour count: 4-bit sum of the 8 neighbours, computed combinationally from the current board. All 256 cells update in the same edge.
- Edge cells: see Configuration.
- gen_count increments on each generation update and holds at 16'hFFFF. It is not cleared by returning to EDIT.
- extinct is combinational, the NOR of all 256 cells.
- The board is retained across RUN -> EDIT and EDIT -> RUN. Only reset clears it.

## Timing
- Reset values:
  - board all 0, so RedPixels = 0;
  - gen_count 0, gen_tick 0, extinct 1;
  - state EDIT, interval counter 0.
- Reset asserted mid-run has the same effect on the next edge. It overrides any generation update or edit in that cycle.
- Edit latency: a strobe sampled at edge N is visible on RedPixels after edge N. This is one cycle of latency.
- Entering RUN: start_game is sampled high at edge N (state becomes RUN). The first generation loads at edge N+GEN_INTERVAL.
  - The counter wraps after each generation, so subsequent generations follow every GEN_INTERVAL edges.
- gen_tick is registered and high for exactly the cycle after the update edge.
- start_game dropping at the same edge the counter hits GEN_INTERVAL-1: the generation still commits, then the state becomes EDIT.
- A strobe in the same cycle that start_game rises: the edit is applied, because the state is still EDIT at that edge.

## Configuration
- GOL_WRAP_EN defined: toroidal board.
  - Row 0 neighbours row 15, and column 0 neighbours column 15.
  - Corners see the three diagonal/edge cells across both wraps.
- GOL_WRAP_EN undefined: neighbours outside 0..15 count as dead (fixed dead border).

## Test plan
- Reset, then edit strobes at (7,6), (7,7), (7,8) with cell_state = 1 -> RedPixels row 7 = 16'h01C0 one cycle after the last strobe; extinct = 0; gen_count = 0.
- Blinker, GEN_INTERVAL = 4, start_game = 1 -> after 4 edges: column 7 set in rows 6..8 only, gen_tick pulses once, gen_count = 1. After 4 more edges: horizontal pattern restored, gen_count = 2.
- Edge strobes during RUN, and in EDIT with row_select = 16 -> board unchanged in both cases.
- Cells at (0,15), (0,0), (0,1), one generation:
  - with GOL_WRAP_EN: (15,0), (0,0), (1,0) set, extinct = 0.
  - without GOL_WRAP_EN: board empty, extinct = 1.
- Reset asserted during RUN after 3 generations -> next cycle: RedPixels = 0, gen_count = 0, extinct = 1, gen_tick = 0, state EDIT; edits are accepted again.
- start_game dropped the cycle the counter equals GEN_INTERVAL-1 -> that generation commits with gen_tick pulse, then no further updates for 10 idle cycles.
